uart_shoot_scheduler: RTL and testbench

Sequences one switching frame across the 9 inverter-module UART links and fires the global shoot pulse. It accepts a frame of 9 per-module transistor bytes from the SPI front end and broadcasts them to the uart_tx instances. It then collects echo acknowledgements from the uart_rx instances. The block asserts shoot only when every module has confirmed its byte; otherwise it aborts with an error mask. It sits between the SPI receive path and the uart_tx/uart_rx array in the top-level FPGA design.

---
 rtl/uart_shoot_scheduler_pkg.sv | 25 ++
 rtl/uart_shoot_scheduler_ack_collector.sv | 58 +++++
 rtl/uart_shoot_scheduler.sv | 125 ++++++++++++
 tb/tb_uart_shoot_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_shoot_scheduler_pkg.sv
// Shared constants for the shoot scheduler: FSM encodings, default sizing
// and cycle counts derived from the 48 MHz system clock.
package uart_shoot_scheduler_pkg;

  localparam int CLK_HZ        = 48_000_000;
  localparam int CYCLES_PER_US = CLK_HZ / 1_000_000;

  localparam int N_MOD_DEF        = 9;
  localparam int GUARD_CYCLES_DEF = 2;
  localparam int ACK_TIMEOUT_DEF  = 100 * CYCLES_PER_US;
  localparam int SHOOT_CYCLES_DEF = 1 * CYCLES_PER_US;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LAUNCH   = 3'd1;
  localparam logic [2:0] ST_WAIT_TX  = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_SHOOT    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_ABORT    = 3'd6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_shoot_scheduler_ack_collector.sv
// Per-module echo bookkeeping: one ack bit and one error bit per UART lane.
// all_acked/any_err look at the values that will be stored at the next edge,
// so the FSM can react to the final echo in the same cycle it arrives.
module uart_shoot_scheduler_ack_collector
  import uart_shoot_scheduler_pkg::*;
#(
  parameter int N_MOD = N_MOD_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic               timeout,
  input  logic [N_MOD-1:0]   rx_done,
  input  logic [8*N_MOD-1:0] data_received,
  input  logic [N_MOD-1:0]   parity_error,
  input  logic [8*N_MOD-1:0] expected,
  output logic [N_MOD-1:0]   err_mask,
  output logic               all_acked,
  output logic               any_err
);

  logic [N_MOD-1:0] ack;
  logic [N_MOD-1:0] bad;
  logic [N_MOD-1:0] new_ack;
  logic [N_MOD-1:0] ack_n;
  logic [N_MOD-1:0] err_pre;

  // A lane's echo is bad if the UART flagged parity or the byte differs.
  always_comb begin
    bad = '0;
    for (int i = 0; i < N_MOD; i++) begin
      bad[i] = parity_error[i] || (data_received[8*i +: 8] != expected[8*i +: 8]);
    end
  end

  // Only the first echo per lane counts; repeats are masked by ack.
  assign new_ack   = en ? (rx_done & ~ack) : '0;
  assign ack_n     = ack | new_ack;
  assign err_pre   = err_mask | (new_ack & bad);
  assign all_acked = &ack_n;
  assign any_err   = |err_pre;

  // Ack/error state: cleared on frame accept, lanes still missing at timeout become errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack      <= '0;
      err_mask <= '0;
    end else if (clear) begin
      ack      <= '0;
      err_mask <= '0;
    end else begin
      ack      <= ack_n;
      err_mask <= err_pre | (timeout ? ~ack_n : '0);
    end
  end

endmodule

// File: rtl/uart_shoot_scheduler.sv
// Frame sequencer between the SPI receive path and the module UART array:
// broadcast one byte per module, collect echoes, then shoot or abort.
//
// Handshake: a frame transfers on a clk edge where frame_valid && frame_ready.
// frame_ready is high only in IDLE; frame_valid seen in any other state is
// ignored and nothing is queued.
module uart_shoot_scheduler
  import uart_shoot_scheduler_pkg::*;
#(
  parameter int N_MOD        = N_MOD_DEF,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int SHOOT_CYCLES = SHOOT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_valid,
  input  logic [8*N_MOD-1:0] frame_data,
  output logic               frame_ready,
  output logic [N_MOD-1:0]   start_tx,
  output logic [8*N_MOD-1:0] data_to_tx,
  input  logic [N_MOD-1:0]   tx_busy,
  input  logic [N_MOD-1:0]   rx_done,
  input  logic [8*N_MOD-1:0] data_received,
  input  logic [N_MOD-1:0]   parity_error,
  output logic               shoot,
  output logic               frame_done,
  output logic               frame_err,
  output logic [N_MOD-1:0]   err_mask,
  output logic               busy,
  output logic [2:0]         state_dbg
);

  localparam int CW = $clog2(max_int(ACK_TIMEOUT, SHOOT_CYCLES) + 1);
  localparam logic [CW-1:0] GUARD      = CW'(GUARD_CYCLES);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] SHOOT_LAST = CW'(SHOOT_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          accept;
  logic          timeout;
  logic          all_acked;
  logic          any_err;

  // Outputs decode straight from the registered state, so an async reset
  // drops shoot without waiting for a clock edge.
  assign frame_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign accept      = frame_valid && frame_ready;
  assign start_tx    = {N_MOD{state == ST_LAUNCH}};
  assign shoot       = (state == ST_SHOOT);
  assign frame_done  = (state == ST_DONE);
  assign frame_err   = (state == ST_ABORT);
  assign state_dbg   = state;
  assign timeout     = (state == ST_WAIT_ACK) && (cnt == ACK_LAST) && !all_acked;

  uart_shoot_scheduler_ack_collector #(.N_MOD(N_MOD)) u_ack (
    .clk           (clk),
    .reset         (reset),
    .clear         (accept),
    .en            (state == ST_WAIT_ACK),
    .timeout       (timeout),
    .rx_done       (rx_done),
    .data_received (data_received),
    .parity_error  (parity_error),
    .expected      (data_to_tx),
    .err_mask      (err_mask),
    .all_acked     (all_acked),
    .any_err       (any_err)
  );

  // Next-state logic; a completing ack wins over a coincident timeout.
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    case (state)
      ST_IDLE:     if (accept) state_n = ST_LAUNCH;
      ST_LAUNCH: begin
        state_n = ST_WAIT_TX;
        cnt_clr = 1'b1;
      end
      ST_WAIT_TX: begin
        if ((cnt >= GUARD) && (tx_busy == '0)) begin
          state_n = ST_WAIT_ACK;
          cnt_clr = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (all_acked) begin
          state_n = any_err ? ST_ABORT : ST_SHOOT;
          cnt_clr = 1'b1;
        end else if (timeout) begin
          state_n = ST_ABORT;
        end
      end
      ST_SHOOT:    if (cnt == SHOOT_LAST) state_n = ST_DONE;
      ST_DONE:     state_n = ST_IDLE;
      ST_ABORT:    state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Shared phase counter; saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (cnt_clr)      cnt <= '0;
    else if (cnt != '1)    cnt <= cnt + CW'(1);
  end

  // Frame bytes captured on accept and held for the whole frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      data_to_tx <= '0;
    else if (accept) data_to_tx <= frame_data;
  end

endmodule

// File: tb/tb_uart_shoot_scheduler.sv
// Bench for uart_shoot_scheduler: a driver task plays SPI source and UART
// array, a reference model predicts each frame's outcome/mask/timing into a
// queue, and a negedge monitor pops and compares whenever the DUT ends a frame.
module tb_uart_shoot_scheduler;

  localparam int N        = 9;
  localparam int ACK_TO   = 4800;
  localparam int SHOOT_N  = 48;
  localparam int BUSY_CYC = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            frame_valid = 1'b0;
  logic [8*N-1:0]  frame_data = '0;
  logic            frame_ready;
  logic [N-1:0]    start_tx;
  logic [8*N-1:0]  data_to_tx;
  logic [N-1:0]    tx_busy = '0;
  logic [N-1:0]    rx_done = '0;
  logic [8*N-1:0]  data_received = '0;
  logic [N-1:0]    parity_error = '0;
  logic            shoot;
  logic            frame_done;
  logic            frame_err;
  logic [N-1:0]    err_mask;
  logic            busy;
  logic [2:0]      state_dbg;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int launches = 0;
  int frames_pushed = 0;

  // Entry: {ok, err_mask[8:0], key cycle}; key cycle is shoot rise for ok
  // frames and the frame_err cycle for aborted ones.
  logic [41:0] exp_q[$];
  logic [71:0] cur_bytes = '0;

  uart_shoot_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .frame_ready   (frame_ready),
    .start_tx      (start_tx),
    .data_to_tx    (data_to_tx),
    .tx_busy       (tx_busy),
    .rx_done       (rx_done),
    .data_received (data_received),
    .parity_error  (parity_error),
    .shoot         (shoot),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_mask      (err_mask),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // Clock and cycle count (posedges seen so far).
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [71:0] act, input logic [71:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard.
  logic [N-1:0] prev_start = '0;
  logic         prev_shoot = 1'b0;
  int           shoot_len = 0;
  logic [41:0]  mon_e;
  int           exp_c;

  always @(negedge clk) begin
    if (!reset) begin
      prev_start = '0;
      prev_shoot = 1'b0;
      shoot_len  = 0;
    end else begin
      if (prev_start != '0) check(start_tx == '0, "start_tx_width", 72'(start_tx), 72'(0));
      if (start_tx != '0) begin
        launches++;
        check(start_tx == 9'h1FF, "start_tx_value", 72'(start_tx), 72'h1FF);
        check(data_to_tx == cur_bytes, "data_to_tx_launch", data_to_tx, cur_bytes);
      end
      if (shoot && !prev_shoot) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "shoot_unexpected", 72'(1), 72'(0));
        end else begin
          check(exp_q[0][41] == 1'b1, "shoot_allowed", 72'(1), 72'(exp_q[0][41]));
          check(cyc == int'(exp_q[0][31:0]), "shoot_rise_cycle", 72'(cyc), 72'(exp_q[0][31:0]));
        end
      end
      if (shoot) shoot_len++;
      if (!shoot && prev_shoot) begin
        check(shoot_len == SHOOT_N, "shoot_width", 72'(shoot_len), 72'(SHOOT_N));
        shoot_len = 0;
      end
      if (frame_done || frame_err) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "frame_end_unexpected", 72'({frame_done, frame_err}), 72'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check((frame_done == mon_e[41]) && (frame_err == !mon_e[41]), "outcome",
                72'({frame_done, frame_err}), 72'({mon_e[41], !mon_e[41]}));
          check(err_mask == mon_e[40:32], "err_mask", 72'(err_mask), 72'(mon_e[40:32]));
          exp_c = mon_e[41] ? int'(mon_e[31:0]) + SHOOT_N : int'(mon_e[31:0]);
          check(cyc == exp_c, "end_cycle", 72'(cyc), 72'(exp_c));
          check(data_to_tx == cur_bytes, "data_to_tx_held", data_to_tx, cur_bytes);
        end
      end
      prev_start = start_tx;
      prev_shoot = shoot;
    end
  end

  // Driver + reference model for one frame.
  // dmode: 0 random echo delays, 1 staggered, 2 all simultaneous,
  //        3 lane 2 first with a duplicate echo, others later.
  task automatic run_frame(input logic [71:0] bytes, input logic [71:0] echo, input logic [8:0] par,
                           input logic [8:0] never, input int dmode, input bit hold, input bit rst_mid);
    int d[N];
    int tmax;
    int dup_t;
    int k;
    bit got;
    logic [8:0]  mask;
    logic [31:0] ecyc;
    logic [95:0] r;

    for (int i = 0; i < N; i++) begin
      case (dmode)
        0:       d[i] = $urandom_range(0, 30);
        1:       d[i] = 3 * i + 1;
        2:       d[i] = 0;
        default: d[i] = (i == 2) ? 0 : $urandom_range(5, 25);
      endcase
    end
    dup_t = (dmode == 3) ? 3 : -1;
    tmax  = dup_t;
    mask  = '0;
    for (int i = 0; i < N; i++) begin
      if (never[i]) begin
        mask[i] = 1'b1;
      end else begin
        if ((echo[8*i +: 8] != bytes[8*i +: 8]) || par[i]) mask[i] = 1'b1;
        if (d[i] > tmax) tmax = d[i];
      end
    end

    got = 1'b0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      got = frame_ready;
    end
    if (!got) check(1'b0, "frame_ready_wait", 72'(0), 72'(1));
    cur_bytes   = bytes;
    frame_valid = 1'b1;
    frame_data  = bytes;
    @(posedge clk); #1;
    r = {$urandom, $urandom, $urandom};
    frame_data = r[71:0];
    if (!hold) frame_valid = 1'b0;
    @(posedge clk); #1;
    tx_busy = '1;
    repeat (BUSY_CYC) @(posedge clk);
    #1;
    tx_busy = '0;
    k = cyc;
    ecyc = (never != '0) ? 32'(k + 1 + ACK_TO) : 32'(k + 2 + tmax);
    exp_q.push_back({(mask == '0), mask, ecyc});
    frames_pushed++;

    for (int t = 0; t <= tmax; t++) begin
      @(posedge clk); #1;
      r = {$urandom, $urandom, $urandom};
      data_received = r[71:0];
      parity_error  = 9'($urandom);
      rx_done       = '0;
      for (int i = 0; i < N; i++) begin
        if (!never[i] && d[i] == t) begin
          rx_done[i] = 1'b1;
          data_received[8*i +: 8] = echo[8*i +: 8];
          parity_error[i] = par[i];
        end
      end
      if (t == dup_t) begin
        rx_done[2] = 1'b1;
        data_received[23:16] = ~bytes[23:16];
        parity_error[2] = 1'b1;
      end
    end
    @(posedge clk); #1;
    rx_done = '0;

    if (rst_mid) begin
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
        @(negedge clk);
        got = shoot;
      end
      check(got, "shoot_seen", 72'(got), 72'(1));
      repeat (10) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check(shoot == 1'b0, "shoot_drop_on_reset", 72'(shoot), 72'(0));
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check(frame_ready == 1'b1, "ready_after_reset", 72'(frame_ready), 72'(1));
      check(err_mask == '0, "err_mask_after_reset", 72'(err_mask), 72'(0));
      check(busy == 1'b0, "busy_after_reset", 72'(busy), 72'(0));
    end else begin
      got = 1'b0;
      for (int w = 0; w < ACK_TO + 300 && !got; w++) begin
        @(negedge clk);
        got = frame_done || frame_err;
      end
      check(got, "frame_end_wait", 72'(got), 72'(1));
      if (hold) begin
        @(posedge clk); #1;
        frame_valid = 1'b0;
      end
    end
  endtask

  // Main sequence.
  initial begin
    logic [71:0] b;
    logic [71:0] e;
    logic [8:0]  p;
    logic [95:0] r;

    repeat (3) @(posedge clk);
    #1;
    check(frame_ready == 1'b1, "rst_frame_ready", 72'(frame_ready), 72'(1));
    check(shoot == 1'b0, "rst_shoot", 72'(shoot), 72'(0));
    check(start_tx == '0, "rst_start_tx", 72'(start_tx), 72'(0));
    check({frame_done, frame_err} == 2'b00, "rst_pulses", 72'({frame_done, frame_err}), 72'(0));
    check(err_mask == '0, "rst_err_mask", 72'(err_mask), 72'(0));
    check(data_to_tx == '0, "rst_data_to_tx", data_to_tx, 72'(0));
    check(busy == 1'b0, "rst_busy", 72'(busy), 72'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    b = 72'h09_08_07_06_05_04_03_02_01;
    run_frame(b, b, 9'h000, 9'h000, 1, 1'b0, 1'b0);        // nominal
    e = b;
    e[39:32] = 8'h55;
    run_frame(b, e, 9'h000, 9'h000, 1, 1'b0, 1'b0);        // bad echo lane 4
    run_frame(b, b, 9'h100, 9'h000, 1, 1'b0, 1'b0);        // parity lane 8
    run_frame(b, b, 9'h000, 9'h001, 1, 1'b0, 1'b0);        // lane 0 silent

    r = {$urandom, $urandom, $urandom};
    run_frame(r[71:0], r[71:0], 9'h000, 9'h000, 3, 1'b1, 1'b0);  // held valid + duplicate
    r = {$urandom, $urandom, $urandom};
    run_frame(r[71:0], r[71:0], 9'h000, 9'h000, 2, 1'b0, 1'b0);  // all echoes at once

    for (int n = 0; n < 8; n++) begin
      r = {$urandom, $urandom, $urandom};
      e = r[71:0];
      p = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) e[8*i +: 8] = e[8*i +: 8] ^ (8'h01 << $urandom_range(0, 7));
        p[i] = ($urandom_range(0, 9) == 0);
      end
      run_frame(r[71:0], e, p, 9'h000, 0, 1'b0, 1'b0);
    end

    run_frame(b, b, 9'h000, 9'h000, 0, 1'b0, 1'b1);        // reset mid-shoot

    repeat (5) @(posedge clk);
    #1;
    check(launches == frames_pushed, "launch_count", 72'(launches), 72'(frames_pushed));
    check(exp_q.size() == 0, "scoreboard_drained", 72'(exp_q.size()), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
